// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper-motor PIO output peripheral:
// register word addresses, CONTROL/STATUS bit positions, the 8-entry
// half-step coil table and the sequencer FSM state type.
package stepper_pkg;

    localparam logic [2:0] ADDR_CONTROL  = 3'd0;
    localparam logic [2:0] ADDR_PERIOD   = 3'd1;
    localparam logic [2:0] ADDR_STEPS    = 3'd2;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd3;
    localparam logic [2:0] ADDR_STATUS   = 3'd4;
    localparam logic [2:0] ADDR_PHASE    = 3'd5;

    localparam int CTRL_RUN  = 0;
    localparam int CTRL_DIR  = 1;
    localparam int CTRL_FULL = 2;
    localparam int CTRL_CONT = 3;
    localparam int CTRL_HOLD = 4;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    // Coil patterns {A, B, A', B'}; entry 0 sits in the lowest nibble.
    localparam logic [7:0][3:0] PHASE_TABLE = {
        4'b1001, 4'b0001, 4'b0011, 4'b0010,
        4'b0110, 4'b0100, 4'b1100, 4'b1000
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [3:0] phase_pattern(input logic [2:0] idx);
        return PHASE_TABLE[idx];
    endfunction

endpackage

// File: rtl/stepper_step_timer.sv
// Step-period prescaler: a down-counter that raises tick for one cycle
// when it reaches zero while enabled, then reloads itself.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   load         : force count to load_val (start of a run)
//   load_val     : reload value, cycles-per-step minus one
//   en           : count while high
//   tick         : one-cycle step strobe
module stepper_step_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tick
);

    logic [W-1:0] count;

    assign tick = en && !load && (count == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= (count == '0) ? load_val : count - W'(1);
        end
    end

endmodule

// File: rtl/stepper_pio_drive.sv
// Avalon-MM slave that sequences the four stepper coil lines.
// Software programs PERIOD/STEPS/CONTROL; the block steps through the
// phase table, counts down remaining steps and flags completion.
// Optional feature macro: STEPPER_PIO_HOLD_EN (CONTROL.HOLD keeps the last
// coil pattern while idle; without it the coils are released in IDLE).
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   address, chipselect,
//   write_n, writedata    : Avalon-MM write/read select
//   readdata              : registered read data, one cycle latency
//   irq                   : |(status_sticky & irq_mask)
//   out_port              : coil drive {A, B, A', B'}
//
// state | meaning
// IDLE  | stopped; coils released (or held with HOLD)
// RUN   | prescaler running, one table step per period
module stepper_pio_drive
    import stepper_pkg::*;
#(
    parameter int PERIOD_W = 24,
    parameter int COUNT_W  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic [3:0]  out_port
);

    logic                wr_en, wr_ctrl, wr_period, wr_steps, wr_mask, wr_status;
    logic                ctrl_dir, ctrl_full, ctrl_cont, hold_eff;
    logic [PERIOD_W-1:0] period, reload_val;
    logic [COUNT_W-1:0]  remaining;
    logic [1:0]          irq_mask, status_sticky;
    logic [2:0]          index, index_step, index_next;
    state_t              state, state_next;
    logic                enter_run, step, finish, tick, busy;
    logic [31:0]         rd_next;
    logic                unused_wdata;

    assign wr_en     = chipselect && !write_n;
    assign wr_ctrl   = wr_en && (address == ADDR_CONTROL);
    assign wr_period = wr_en && (address == ADDR_PERIOD);
    assign wr_steps  = wr_en && (address == ADDR_STEPS);
    assign wr_mask   = wr_en && (address == ADDR_IRQ_MASK);
    assign wr_status = wr_en && (address == ADDR_STATUS);
    assign unused_wdata = ^writedata[31:PERIOD_W];

    assign busy       = (state == RUN);
    // PERIOD of 0 behaves as 1: reload value clamps at 0.
    assign reload_val = (period == '0) ? '0 : period - PERIOD_W'(1);
    assign index_step = ctrl_full ? 3'd2 : 3'd1;
    assign index_next = ctrl_dir ? index - index_step : index + index_step;

    stepper_step_timer #(.W(PERIOD_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (enter_run),
        .load_val (reload_val),
        .en       (busy),
        .tick     (tick)
    );

`ifdef STEPPER_PIO_HOLD_EN
    logic ctrl_hold;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     ctrl_hold <= 1'b0;
        else if (wr_ctrl) ctrl_hold <= writedata[CTRL_HOLD];
    end
    assign hold_eff = ctrl_hold;
`else
    assign hold_eff = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // A RUN=0 write beats a simultaneous tick; a STEPS write in the same
    // cycle as the final tick replaces the count, so that tick cannot finish.
    always_comb begin
        state_next = state;
        enter_run  = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (wr_ctrl && writedata[CTRL_RUN] &&
                    (remaining != '0 || writedata[CTRL_CONT])) begin
                    enter_run  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (wr_ctrl && !writedata[CTRL_RUN]) begin
                    state_next = IDLE;
                end else if (tick) begin
                    step = 1'b1;
                    if (!ctrl_cont && !wr_steps && remaining <= COUNT_W'(1)) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_dir      <= 1'b0;
            ctrl_full     <= 1'b0;
            ctrl_cont     <= 1'b0;
            period        <= PERIOD_W'(1);
            remaining     <= '0;
            irq_mask      <= '0;
            status_sticky <= '0;
            index         <= '0;
            out_port      <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_dir  <= writedata[CTRL_DIR];
                ctrl_full <= writedata[CTRL_FULL];
                ctrl_cont <= writedata[CTRL_CONT];
            end
            if (wr_period) period <= writedata[PERIOD_W-1:0];
            if (wr_mask)   irq_mask <= writedata[1:0];

            if (wr_steps)
                remaining <= writedata[COUNT_W-1:0];
            else if (step && !ctrl_cont && remaining != '0)
                remaining <= remaining - COUNT_W'(1);

            // Event sets take priority over a STATUS clear in the same cycle.
            status_sticky[STAT_BUSY] <= (status_sticky[STAT_BUSY] && !wr_status) || enter_run;
            status_sticky[STAT_DONE] <= (status_sticky[STAT_DONE] && !wr_status) || finish;

            if (step) index <= index_next;

            if (busy) begin
                if (step) out_port <= phase_pattern(index_next);
            end else if (enter_run) begin
                out_port <= phase_pattern(index);
            end else if (!hold_eff) begin
                out_port <= '0;
            end
        end
    end

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_CONTROL: begin
                rd_next[CTRL_RUN]  = busy;
                rd_next[CTRL_DIR]  = ctrl_dir;
                rd_next[CTRL_FULL] = ctrl_full;
                rd_next[CTRL_CONT] = ctrl_cont;
                rd_next[CTRL_HOLD] = hold_eff;
            end
            ADDR_PERIOD:   rd_next = 32'(period);
            ADDR_STEPS:    rd_next = 32'(remaining);
            ADDR_IRQ_MASK: rd_next = 32'(irq_mask);
            ADDR_STATUS: begin
                rd_next[STAT_BUSY] = busy;
                rd_next[STAT_DONE] = status_sticky[STAT_DONE];
            end
            ADDR_PHASE:    rd_next = 32'(index);
            default:       rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_next;
    end

    assign irq = |(status_sticky & irq_mask);

endmodule

// File: tb/tb_stepper_pio_drive.sv
// Scoreboard bench for stepper_pio_drive: the driver pushes expected coil
// events, read data and probes into queues; a negedge monitor pops and
// compares whenever the DUT presents a coil change or read data.
module tb_stepper_pio_drive;

    localparam logic [2:0] A_CTRL = 3'd0, A_PER = 3'd1, A_STEPS = 3'd2,
                           A_MASK = 3'd3, A_STAT = 3'd4, A_PHASE = 3'd5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;
    logic [3:0]  out_port;

    stepper_pio_drive dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] pat; logic irq; int cyc; } out_ev_t;
    typedef struct { logic [31:0] exp; int addr; } rd_ev_t;
    typedef struct { int kind; logic [31:0] exp; } probe_t;

    out_ev_t out_q[$];
    rd_ev_t  rd_q[$];
    probe_t  probe_q[$];

    logic [3:0] tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                            4'b0010, 4'b0011, 4'b0001, 4'b1001};

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic rd_seen = 1'b0;
    logic [3:0] prev_out = 4'b0000;
    int model_idx = 0;

`ifdef STEPPER_PIO_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rd_seen <= chipselect && write_n;

    always @(negedge clk) begin : monitor
        out_ev_t e;
        rd_ev_t  r;
        probe_t  p;
        if (rd_seen) begin
            checks++;
            if (rd_q.size() == 0) begin
                failures++;
                $display("FAIL read_unexpected: got 0x%08h want no read", readdata);
            end else begin
                r = rd_q.pop_front();
                if (readdata !== r.exp) begin
                    failures++;
                    $display("FAIL read addr%0d: got 0x%08h want 0x%08h", r.addr, readdata, r.exp);
                end
            end
        end
        if (out_port !== prev_out) begin
            checks++;
            if (out_q.size() == 0) begin
                failures++;
                $display("FAIL out_unexpected: got %b at cyc %0d want no change", out_port, cyc);
            end else begin
                e = out_q.pop_front();
                if (out_port !== e.pat || irq !== e.irq || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL out_event: got pat=%b irq=%b cyc=%0d want pat=%b irq=%b cyc=%0d",
                             out_port, irq, cyc, e.pat, e.irq, e.cyc);
                end
            end
        end
        prev_out = out_port;
        while (probe_q.size() > 0) begin
            p = probe_q.pop_front();
            checks++;
            case (p.kind)
                0: if (out_port !== p.exp[3:0]) begin
                       failures++;
                       $display("FAIL probe_out_port: got %b want %b", out_port, p.exp[3:0]);
                   end
                1: if (irq !== p.exp[0]) begin
                       failures++;
                       $display("FAIL probe_irq: got %b want %b", irq, p.exp[0]);
                   end
                default: if (out_q.size() + rd_q.size() != int'(p.exp)) begin
                       failures++;
                       $display("FAIL drain_timeout: got %0d pending want %0d",
                                out_q.size() + rd_q.size(), p.exp);
                   end
            endcase
        end
    end

    task automatic probe(input int kind, input logic [31:0] exp);
        probe_t p;
        p.kind = kind;
        p.exp  = exp;
        probe_q.push_back(p);
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic do_read(input logic [2:0] a, input logic [31:0] exp);
        rd_ev_t r;
        r.exp = exp;
        r.addr = int'(a);
        rd_q.push_back(r);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        @(negedge clk);
        chipselect = 1'b0;
    endtask

    task automatic push_out(input logic [3:0] pat, input logic i, input int c);
        out_ev_t e;
        e.pat = pat; e.irq = i; e.cyc = c;
        out_q.push_back(e);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_drain();
        int budget = 600;
        while ((out_q.size() + rd_q.size()) != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        probe(2, 0);
        @(negedge clk);
    endtask

    task automatic apply_reset(input bit expect_change);
        #1 reset_n = 1'b0;
        if (expect_change) push_out(4'b0000, 1'b0, cyc + 1);
        @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        model_idx = 0;
    endtask

    function automatic int wrap8(input int v);
        return ((v % 8) + 8) % 8;
    endfunction

    // Counted run: coil pattern k appears k*max(P,1) cycles after the
    // CONTROL write edge; coils release one cycle after the run ends.
    task automatic run_counted(input int p, input int n, input bit dir, input bit full,
                               input bit hold, input logic [1:0] mask,
                               input bit stop_at_final, output int ew);
        int peff = (p == 0) ? 1 : p;
        int s = (full ? 2 : 1) * (dir ? -1 : 1);
        int last = stop_at_final ? n - 1 : n;
        logic fin_irq = mask[0] | (mask[1] & !stop_at_final);
        do_write(A_PER, 32'(p));
        do_write(A_STEPS, 32'(n));
        do_write(A_MASK, 32'(mask));
        ew = cyc + 1;
        for (int k = 0; k <= last; k++)
            push_out(tbl[wrap8(model_idx + k * s)], (k == n) ? fin_irq : mask[0], ew + k * peff);
        if (!hold) push_out(4'b0000, fin_irq, ew + n * peff + 1);
        model_idx = wrap8(model_idx + last * s);
        do_write(A_CTRL, {27'b0, hold, 1'b0, full, dir, 1'b1});
    endtask

    function automatic logic [31:0] ctrl_rb(input bit dir, input bit full, input bit cont, input bit hold);
        return {27'b0, hold & HOLD_EN, cont, full, dir, 1'b0};
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int ew;
        int pr, nr;
        bit dr, fr;
        logic [1:0] mr;

        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);

        // Reset state; write to an unused address must not alias.
        probe(0, 0);
        probe(1, 0);
        do_write(3'd6, 32'hFFFF_FFFF);
        for (int a = 0; a < 8; a++) do_read(3'(a), (a == 1) ? 32'd1 : 32'd0);
        wait_drain();

        // Forward half-step, 3 steps, period 4.
        run_counted(4, 3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, ew);
        wait_drain();
        do_read(A_STAT, 32'h2);
        do_read(A_CTRL, ctrl_rb(0, 0, 0, 0));
        do_read(A_STEPS, 32'd0);
        do_read(A_PHASE, 32'd3);
        wait_drain();

        // Reverse full-step from index 0 with DONE interrupt.
        apply_reset(1'b0);
        run_counted(2, 2, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, ew);
        wait_drain();
        probe(1, 1);
        do_read(A_PHASE, 32'd4);
        do_read(A_CTRL, ctrl_rb(1, 1, 0, 0));
        do_write(A_STAT, 32'h0);
        probe(1, 0);
        do_read(A_STAT, 32'h0);
        wait_drain();

        // Continuous mode at one step per clock, wraps, stopped by RUN=0.
        do_write(A_MASK, 32'h0);
        do_write(A_PER, 32'd1);
        do_write(A_STEPS, 32'd5);
        ew = cyc + 1;
        for (int k = 0; k < 10; k++) push_out(tbl[wrap8(model_idx + k)], 1'b0, ew + k);
        push_out(4'b0000, 1'b0, ew + 11);
        model_idx = wrap8(model_idx + 9);
        do_write(A_CTRL, 32'h9);
        wait_cyc(ew + 9);
        do_write(A_CTRL, 32'h8);
        wait_drain();
        do_read(A_STEPS, 32'd5);
        do_read(A_STAT, 32'h0);
        do_read(A_CTRL, ctrl_rb(0, 0, 1, 0));
        do_read(A_PHASE, 32'(model_idx));
        wait_drain();

        // Final step coincides with a STATUS write: DONE set wins.
        do_write(A_STAT, 32'h0);
        run_counted(3, 2, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, ew);
        wait_cyc(ew + 5);
        do_write(A_STAT, 32'h0);
        wait_drain();
        do_read(A_STAT, 32'h2);
        probe(1, 1);
        do_write(A_STAT, 32'h0);
        wait_drain();

        // Final step coincides with RUN=0: no step, no DONE.
        run_counted(3, 2, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, ew);
        wait_cyc(ew + 5);
        do_write(A_CTRL, 32'h0);
        wait_drain();
        do_read(A_STAT, 32'h0);
        do_read(A_STEPS, 32'd1);
        do_read(A_PHASE, 32'(model_idx));
        probe(1, 0);
        wait_drain();

        if (HOLD_EN) begin
            run_counted(2, 3, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, ew);
            wait_drain();
            repeat (4) @(negedge clk);
            probe(0, 32'(tbl[model_idx]));
            do_read(A_CTRL, ctrl_rb(0, 1, 0, 1));
            push_out(4'b0000, 1'b0, cyc + 2);
            do_write(A_CTRL, 32'h0);
            wait_drain();
            do_write(A_STAT, 32'h0);
        end

        // Randomised counted runs.
        for (int it = 0; it < 12; it++) begin
            pr = int'($urandom_range(0, 4));
            nr = int'($urandom_range(1, 5));
            dr = 1'($urandom_range(0, 1));
            fr = 1'($urandom_range(0, 1));
            mr = 2'($urandom_range(0, 3));
            run_counted(pr, nr, dr, fr, 1'b0, mr, 1'b0, ew);
            wait_drain();
            do_read(A_STAT, 32'h2);
            do_read(A_STEPS, 32'd0);
            do_read(A_CTRL, ctrl_rb(dr, fr, 0, 0));
            do_read(A_PHASE, 32'(model_idx));
            do_write(A_STAT, 32'h0);
            wait_drain();
        end

        // Reset asserted mid-run.
        do_write(A_MASK, 32'h0);
        do_write(A_PER, 32'd20);
        do_write(A_STEPS, 32'd5);
        push_out(tbl[model_idx], 1'b0, cyc + 1);
        do_write(A_CTRL, 32'h1);
        wait_drain();
        repeat (3) @(negedge clk);
        apply_reset(1'b1);
        do_read(A_PER, 32'd1);
        do_read(A_STEPS, 32'd0);
        do_read(A_CTRL, 32'd0);
        do_read(A_STAT, 32'd0);
        do_read(A_PHASE, 32'd0);
        probe(1, 0);
        wait_drain();

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
